// File: rtl/pio_edge_irq.sv
// Avalon-MM parallel I/O: output port with atomic set/clear,
// input port with sync, debounce, edge capture and masked irq.
module pio_edge_irq #(
  parameter int WIDTH = 10,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE = 0,
  parameter logic [WIDTH-1:0] RESET_OUT = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [2:0]       s0_address,
  input  logic             s0_read,
  input  logic             s0_write,
  input  logic [31:0]      s0_writedata,
  output logic [31:0]      s0_readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] pio_in_export,
  output logic [WIDTH-1:0] pio_out_export
);

  localparam logic [2:0] A_DIN  = 3'd0;
  localparam logic [2:0] A_DOUT = 3'd1;
  localparam logic [2:0] A_SET  = 3'd2;
  localparam logic [2:0] A_CLR  = 3'd3;
  localparam logic [2:0] A_MASK = 3'd4;
  localparam logic [2:0] A_CAP  = 3'd5;

  localparam int SETTLE = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_prev;
  logic             r_irq;
  logic [31:0]      r_rdata;
  logic [SW-1:0]    r_settle;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;

  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_cap_set;
  logic [WIDTH-1:0] w_cap_clr;
  logic [WIDTH-1:0] w_out_nxt;
  logic [WIDTH-1:0] w_rd_val;
  logic             w_wr_dout;
  logic             w_wr_set;
  logic             w_wr_clr;
  logic             w_wr_mask;
  logic             w_wr_cap;
  logic             w_settled;
  logic             w_unused;

  // Bits of writedata above WIDTH are intentionally dropped.
  assign w_wd = s0_writedata[WIDTH-1:0];
  assign w_unused = ^s0_writedata;

  assign w_wr_dout = s0_write && (s0_address == A_DOUT);
  assign w_wr_set  = s0_write && (s0_address == A_SET);
  assign w_wr_clr  = s0_write && (s0_address == A_CLR);
  assign w_wr_mask = s0_write && (s0_address == A_MASK);
  assign w_wr_cap  = s0_write && (s0_address == A_CAP);

  // Next output value: plain write, atomic set or atomic clear.
  always_comb begin
    w_out_nxt = r_out;
    unique case (1'b1)
      w_wr_dout: w_out_nxt = w_wd;
      w_wr_set:  w_out_nxt = r_out | w_wd;
      w_wr_clr:  w_out_nxt = r_out & ~w_wd;
      default:   w_out_nxt = r_out;
    endcase
  end

  // Output register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_out <= RESET_OUT;
    else                r_out <= w_out_nxt;
  end

  assign pio_out_export = r_out;

  // Input synchronizer chain; last stage feeds the debouncer.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= pio_in_export;
      for (int i = 1; i < SYNC_STAGES; i++)
        r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodb
      assign w_stable = w_sync;
    end else begin : g_db
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
      for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [CW-1:0] r_cnt;
        logic          r_stb;
        // Accept a new level only after it has persisted long enough.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
          if (!reset_reset_n) begin
            r_cnt <= '0;
            r_stb <= 1'b0;
          end else if (w_sync[b] == r_stb) begin
            r_cnt <= '0;
          end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
            r_stb <= w_sync[b];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        assign w_stable[b] = r_stb;
      end
    end
  endgenerate

  // Settle guard: hold off capture until the input path has filled.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)   r_settle <= '0;
    else if (!w_settled)  r_settle <= r_settle + 1'b1;
  end

  assign w_settled = (r_settle == SETTLE_END);

  // Previous debounced value, tracked even while settling.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_prev <= '0;
    else                r_prev <= w_stable;
  end

  assign w_rise = w_stable & ~r_prev;
  assign w_fall = ~w_stable & r_prev;

  // Edge selection by configured type.
  always_comb begin
    w_edge = w_rise ^ w_fall;
    unique case (EDGE_TYPE)
      0:       w_edge = w_rise;
      1:       w_edge = w_fall;
      default: w_edge = w_rise ^ w_fall;
    endcase
  end

  assign w_cap_set = w_settled ? w_edge : '0;
  assign w_cap_clr = w_wr_cap ? w_wd : '0;

  // Edge capture; a new edge overrides a same-cycle W1C.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_cap <= '0;
    else                r_cap <= (r_cap & ~w_cap_clr) | w_cap_set;
  end

  // Interrupt mask register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_mask <= '0;
    else if (w_wr_mask) r_mask <= w_wd;
  end

  // Registered level interrupt.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_irq <= 1'b0;
    else                r_irq <= |(r_cap & r_mask);
  end

  assign irq = r_irq;

  // Read mux; write-only and reserved words read as zero.
  always_comb begin
    w_rd_val = '0;
    unique case (s0_address)
      A_DIN:   w_rd_val = w_stable;
      A_DOUT:  w_rd_val = r_out;
      A_MASK:  w_rd_val = r_mask;
      A_CAP:   w_rd_val = r_cap;
      default: w_rd_val = '0;
    endcase
  end

  // Read data holds until the next read strobe.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_rdata <= '0;
    else if (s0_read)   r_rdata <= 32'(w_rd_val);
  end

  assign s0_readdata = r_rdata;

endmodule

// File: doc/pio_edge_irq.md
# pio_edge_irq

Parametrised Avalon-MM parallel I/O peripheral that replaces the fixed 10-bit LED output and slide-switch input PIOs inside the `core` Platform Designer system. It has an output port with atomic set and clear. It also has an input port with a synchronizer, a per-bit debouncer, edge capture, and a masked level interrupt to the Nios II. One instance serves both LEDs and switches, or either one alone.

## Interface
- `WIDTH`, 10: number of input bits and number of output bits (1..32).
- `SYNC_STAGES`, 2: flip-flop stages on each input bit (2..4).
- `DEBOUNCE_CYCLES`, 0: consecutive stable cycles needed to accept an input change. 0 bypasses the debouncer.
- `EDGE_TYPE`, 0: edge to capture. 0 = rising, 1 = falling, 2 = either.
- `RESET_OUT`, 0: reset value of the output register (`WIDTH` bits).
- `clk_clk` input 1: system clock.
- `reset_reset_n` input 1: asynchronous, active-low reset.
- `s0_address` input 3: word address.
- `s0_read` input 1: read strobe.
- `s0_write` input 1: write strobe.
- `s0_writedata` input 32: write data.
- `s0_readdata` output 32: read data, registered.
- `irq` output 1: level interrupt, active high.
- `pio_in_export` input `WIDTH`: asynchronous inputs from the switches.
- `pio_out_export` output `WIDTH`: output register, driven to the LEDs.

## Operation
- Register map (word addresses). Bits above `WIDTH` read as 0 and ignore writes.
  - 0 `DATA_IN`, read-only: debounced input value.
  - 1 `DATA_OUT`, read/write: output register.
  - 2 `OUT_SET`, write-only: OR `writedata` into `DATA_OUT`. Reads return 0.
  - 3 `OUT_CLR`, write-only: AND-NOT `writedata` into `DATA_OUT`. Reads return 0.
  - 4 `IRQ_MASK`, read/write.
  - 5 `EDGE_CAP`, read / write-1-to-clear.
  - 6 and 7: reserved. Reads return 0; writes are ignored.
- Synchronizer: `SYNC_STAGES`-deep shift chain per bit. Its output is `sync`.
- Debouncer (`DEBOUNCE_CYCLES` > 0), per bit:
  - While `sync` differs from `stable`, the counter increments each cycle.
  - When the counter equals `DEBOUNCE_CYCLES`-1 and `sync` still differs, `stable` takes the value of `sync` on the next edge and the counter is cleared.
  - Any cycle with `sync` equal to `stable` clears the counter.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - With `DEBOUNCE_CYCLES` = 0, `stable` equals `sync` (a wire).
- Edge detector:
  - `prev` is a register of `stable`.
  - Rising edge = `stable & ~prev`. Falling edge = `~stable & prev`. Either = the XOR of the two.
  - Each detected edge sets the matching `EDGE_CAP` bit.
- Settle guard:
  - After reset release, a counter suppresses edge capture for `SYNC_STAGES + DEBOUNCE_CYCLES + 1` cycles.
  - `prev` keeps tracking `stable` during this window.
  - Purpose: switches already asserted at power-up must not raise spurious edges.
- `irq` is registered: `irq <= |(EDGE_CAP & IRQ_MASK)`.
- Edge set and W1C clear in the same cycle on the same bit: set wins, and the bit stays 1.
- `OUT_SET`/`OUT_CLR` are single-cycle read-modify-write operations with no bus hazard. Back-to-back writes apply in order.
- Simultaneous `s0_read` and `s0_write`: the write takes effect and `readdata` returns the pre-write value.

## Timing
- Reset values: `pio_out_export` = `RESET_OUT`. All other state is 0: `s0_readdata`, `irq`, `IRQ_MASK`, `EDGE_CAP`, the sync chain, `stable`, `prev`, and the debounce counters. The settle counter restarts.
- Read latency 1: `s0_readdata` is valid on the cycle after `s0_read` and holds until the next read. No wait states.
- Write: a register updates on the edge that samples `s0_write`. `pio_out_export` changes 1 cycle after the write.
- Input to `DATA_IN`: a change that is stable at `pio_in_export` is visible after `SYNC_STAGES + DEBOUNCE_CYCLES` edges.
- `EDGE_CAP` sets 1 cycle after `stable` changes. `irq` asserts 1 cycle after that.
- Writing 1 to the last pending masked bit of `EDGE_CAP` deasserts `irq` 2 cycles after the write edge. The same holds for clearing a bit in `IRQ_MASK`.
- Reset asserted mid-debounce or mid-read: all state clears immediately (asynchronous). The pending change is lost and no edge is captured for it.

## Test plan
- Reset, `RESET_OUT`=10'h155:
  - `pio_out_export`=10'h155 and `irq`=0.
  - Hold `pio_in_export`=10'h3FF through reset release: `EDGE_CAP` stays 0 and no `irq`.
- Write 10'h00F to `OUT_SET`, then 10'h005 to `OUT_CLR`, starting from 0: `pio_out_export` = 10'h00F, then 10'h00A. Reading `DATA_OUT` returns 32'h0000000A.
- With `DEBOUNCE_CYCLES`=4 and `SYNC_STAGES`=2:
  - Toggle bit 3 high for 3 cycles: no change in `DATA_IN`.
  - Hold bit 3 high: `DATA_IN` bit 3 = 1 exactly 6 edges after the input changes.
- Rising mode, `IRQ_MASK`=10'h008, bit 3 rises:
  - `EDGE_CAP`=10'h008, then `irq`=1 one cycle later.
  - Write 10'h008 to `EDGE_CAP`: `irq`=0 2 cycles after the write.
- Edge arrives on the same cycle as a W1C of that bit: `EDGE_CAP` bit stays 1 and `irq` stays 1.
- Reads of addresses 2, 3, 6, 7 return 0. Bits [31:WIDTH] of every read return 0.
